// File: rtl/branch_target_predictor.sv
// ----------------------------------------------------------------------------
// branch_target_predictor
//
// Direct-mapped branch target buffer with a per-entry 2-bit saturating
// direction counter. An optional circular return address stack predicts
// return targets. It is compiled in when the macro BRANCH_PREDICTOR_RAS_EN
// is defined.
//
// Parameters
//   PC_W      instruction-address width
//   IDX_W     BTB index width (2**IDX_W entries, indexed by PC[IDX_W+1:2])
//   RAS_DEPTH return-address-stack entries (only with BRANCH_PREDICTOR_RAS_EN)
//
// Ports
//   CLK          clock, all state changes on the rising edge
//   RSTn         synchronous active-low reset
//   LK_VALID     lookup request this cycle
//   LK_PC        fetch PC to predict
//   PRED_VALID   prediction valid (LK_VALID delayed one cycle)
//   PRED_HIT     looked-up PC hit a valid BTB entry
//   PRED_TAKEN   predicted taken
//   PRED_TARGET  predicted next PC
//   UPD_VALID    resolved control-flow instruction reported this cycle
//   UPD_PC       PC of the resolved instruction
//   UPD_TAKEN    actual direction
//   UPD_TARGET   actual taken target
//   UPD_TYPE     00 cond branch, 01 JAL, 10 JALR call, 11 JALR return
//
// Lookup and update share one edge. The prediction is computed
// combinationally from the current table contents and registered. A
// same-index update in the same cycle is therefore invisible to that lookup
// (read-before-write).
// ----------------------------------------------------------------------------
module branch_target_predictor #(
    parameter int PC_W      = 12,
    parameter int IDX_W     = 6,
    parameter int RAS_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            LK_VALID,
    input  logic [PC_W-1:0] LK_PC,
    output logic            PRED_VALID,
    output logic            PRED_HIT,
    output logic            PRED_TAKEN,
    output logic [PC_W-1:0] PRED_TARGET,
    input  logic            UPD_VALID,
    input  logic [PC_W-1:0] UPD_PC,
    input  logic            UPD_TAKEN,
    input  logic [PC_W-1:0] UPD_TARGET,
    input  logic [1:0]      UPD_TYPE
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;

    localparam logic [1:0] TYPE_COND = 2'b00;
    localparam logic [1:0] TYPE_CALL = 2'b10;
    localparam logic [1:0] TYPE_RET  = 2'b11;

    // ------------------------------------------------------------------
    // BTB storage. Only the valid bits are reset.
    // ------------------------------------------------------------------
    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [PC_W-1:0]   target_q [ENTRIES];
    logic [1:0]        type_q   [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic              pred_valid_q,  pred_valid_d;
    logic              pred_hit_q,    pred_hit_d;
    logic              pred_taken_q,  pred_taken_d;
    logic [PC_W-1:0]   pred_target_q, pred_target_d;

    // ------------------------------------------------------------------
    // Lookup path
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic [PC_W-1:0]   lk_seq_pc;
    logic [PC_W-1:0]   ret_target;

    assign lk_idx    = LK_PC[IDX_W+1:2];
    assign lk_tag    = LK_PC[PC_W-1:IDX_W+2];
    assign lk_hit    = LK_VALID && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    // Fall-through address. The sum is truncated to PC_W, so it wraps.
    assign lk_seq_pc = LK_PC + PC_W'(4);

    always_comb begin
        pred_valid_d  = LK_VALID;
        pred_hit_d    = 1'b0;
        pred_taken_d  = 1'b0;
        pred_target_d = lk_seq_pc;
        if (lk_hit) begin
            pred_hit_d = 1'b1;
            unique case (type_q[lk_idx])
                TYPE_COND: begin
                    pred_taken_d  = ctr_q[lk_idx][1];
                    pred_target_d = ctr_q[lk_idx][1] ? target_q[lk_idx] : lk_seq_pc;
                end
                TYPE_RET: begin
                    pred_taken_d  = 1'b1;
                    pred_target_d = ret_target;
                end
                default: begin
                    pred_taken_d  = 1'b1;
                    pred_target_d = target_q[lk_idx];
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic [1:0]        upd_ctr_d;

    assign upd_idx = UPD_PC[IDX_W+1:2];
    assign upd_tag = UPD_PC[PC_W-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        upd_ctr_d = ctr_q[upd_idx];
        if (UPD_TAKEN) begin
            if (ctr_q[upd_idx] != 2'b11) upd_ctr_d = ctr_q[upd_idx] + 2'b01;
        end else begin
            if (ctr_q[upd_idx] != 2'b00) upd_ctr_d = ctr_q[upd_idx] - 2'b01;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            if (UPD_VALID) begin
                if (upd_hit) begin
                    ctr_q[upd_idx] <= upd_ctr_d;
                    if (UPD_TAKEN) begin
                        target_q[upd_idx] <= UPD_TARGET;
                        type_q[upd_idx]   <= UPD_TYPE;
                    end
                end else if (UPD_TAKEN) begin
                    // Allocate, evicting whatever occupied this index.
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= UPD_TARGET;
                    type_q[upd_idx]   <= UPD_TYPE;
                    ctr_q[upd_idx]    <= 2'b10;
                end
            end
        end
    end

`ifdef BRANCH_PREDICTOR_RAS_EN
    // ------------------------------------------------------------------
    // Circular return address stack. ras_ptr_q is the next push slot, so
    // the top is one slot behind it. When the stack is full, a push
    // overwrites the oldest entry, which is the slot at ras_ptr_q.
    // ------------------------------------------------------------------
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic [PTR_W-1:0] ras_top;
    logic [PTR_W-1:0] ras_ptr_inc;
    logic             ras_push;
    logic             ras_pop;

    assign ras_top     = (ras_ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr_q - PTR_W'(1);
    assign ras_ptr_inc = (ras_ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + PTR_W'(1);
    assign ras_push    = UPD_VALID && (UPD_TYPE == TYPE_CALL);
    assign ras_pop     = UPD_VALID && (UPD_TYPE == TYPE_RET);
    assign ret_target  = (ras_cnt_q != '0) ? ras_q[ras_top] : target_q[lk_idx];

    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_push && !ras_pop) begin
            ras_ptr_d = ras_ptr_inc;
            if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + CNT_W'(1);
        end else if (ras_pop && !ras_push && (ras_cnt_q != '0)) begin
            ras_ptr_d = ras_top;
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            if (ras_push && ras_pop) begin
                // Push and pop together replace the top entry in place.
                ras_q[ras_top] <= UPD_PC + PC_W'(4);
            end else if (ras_push) begin
                ras_q[ras_ptr_q] <= UPD_PC + PC_W'(4);
            end
        end
    end
`else
    assign ret_target = target_q[lk_idx];
`endif

    assign PRED_VALID  = pred_valid_q;
    assign PRED_HIT    = pred_hit_q;
    assign PRED_TAKEN  = pred_taken_q;
    assign PRED_TARGET = pred_target_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;

  localparam int PC_W = 12;
  localparam int PW   = PC_W + 3;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n;
  logic            lk_valid;
  logic [PC_W-1:0] lk_pc;
  logic            pred_valid;
  logic            pred_hit;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic [1:0]      upd_type;

  always #5 clk = ~clk;

  branch_target_predictor #(.PC_W(PC_W), .IDX_W(6), .RAS_DEPTH(4)) dut (
    .CLK(clk), .RSTn(rst_n),
    .LK_VALID(lk_valid), .LK_PC(lk_pc),
    .PRED_VALID(pred_valid), .PRED_HIT(pred_hit),
    .PRED_TAKEN(pred_taken), .PRED_TARGET(pred_target),
    .UPD_VALID(upd_valid), .UPD_PC(upd_pc), .UPD_TAKEN(upd_taken),
    .UPD_TARGET(upd_target), .UPD_TYPE(upd_type)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare the registered prediction against the oldest expected entry.
  task automatic compare_pred(input string tag);
    logic [PW-1:0] e;
    e = exp_q.pop_front();
    check({tag, ".valid"},  32'(pred_valid),  32'(e[PW-1]));
    check({tag, ".hit"},    32'(pred_hit),    32'(e[PW-2]));
    check({tag, ".taken"},  32'(pred_taken),  32'(e[PW-3]));
    check({tag, ".target"}, 32'(pred_target), 32'(e[PC_W-1:0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    lk_valid  = 1'b0;
    upd_valid = 1'b0;
  endtask

  task automatic update(input logic [PC_W-1:0] pc, input logic tk,
                        input logic [PC_W-1:0] tgt, input logic [1:0] ty);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_type = ty;
    step();
  endtask

  task automatic lookup(input string tag, input logic [PC_W-1:0] pc, input logic e_hit,
                        input logic e_taken, input logic [PC_W-1:0] e_tgt);
    exp_q.push_back({1'b1, e_hit, e_taken, e_tgt});
    lk_valid = 1'b1; lk_pc = pc;
    step();
    compare_pred(tag);
  endtask

  // ---------------- stimulus ----------------
  logic [PC_W-1:0] ret_exp [5];

  initial begin
    rst_n = 1'b0; lk_valid = 1'b0; lk_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_type = 2'b00;
    step(); step();
    exp_q.push_back('0);
    compare_pred("reset");
    rst_n = 1'b1;

    lookup("cold_miss", 12'h040, 1'b0, 1'b0, 12'h044);

    // No lookup: valid low, fall-through target still presented.
    exp_q.push_back({3'b000, 12'h127});
    lk_valid = 1'b0; lk_pc = 12'h123;
    step();
    compare_pred("no_lookup");

    lookup("wrap_miss", 12'hFFC, 1'b0, 1'b0, 12'h000);

    update(12'h040, 1'b1, 12'h100, 2'b00);              // alloc ctr=2
    lookup("cond_taken", 12'h040, 1'b1, 1'b1, 12'h100);
    update(12'h040, 1'b0, 12'h000, 2'b00);              // 1
    update(12'h040, 1'b0, 12'h000, 2'b00);              // 0
    lookup("cond_nt", 12'h040, 1'b1, 1'b0, 12'h044);
    update(12'h040, 1'b0, 12'h000, 2'b00);              // stays 0
    update(12'h040, 1'b1, 12'h100, 2'b00);              // 1
    lookup("ctr_floor", 12'h040, 1'b1, 1'b0, 12'h044);
    update(12'h040, 1'b1, 12'h100, 2'b00);              // 2
    update(12'h040, 1'b1, 12'h100, 2'b00);              // 3
    update(12'h040, 1'b1, 12'h180, 2'b00);              // stays 3, new target
    update(12'h040, 1'b0, 12'h000, 2'b00);              // 2
    lookup("ctr_ceiling", 12'h040, 1'b1, 1'b1, 12'h180);

    // Alias at index 16 evicts 0x040.
    update(12'h140, 1'b1, 12'h200, 2'b01);
    lookup("alias_old", 12'h040, 1'b0, 1'b0, 12'h044);
    lookup("alias_new", 12'h140, 1'b1, 1'b1, 12'h200);

    update(12'h0C0, 1'b0, 12'h500, 2'b00);              // not-taken miss: no alloc
    lookup("nt_noalloc", 12'h0C0, 1'b0, 1'b0, 12'h0C4);

    // Same-cycle lookup and allocating update: lookup sees old contents.
    exp_q.push_back({3'b100, 12'h084});
    lk_valid = 1'b1; lk_pc = 12'h080;
    upd_valid = 1'b1; upd_pc = 12'h080; upd_taken = 1'b1; upd_target = 12'h300; upd_type = 2'b00;
    step();
    compare_pred("rbw_same");
    lookup("rbw_next", 12'h080, 1'b1, 1'b1, 12'h300);

    // Return entry allocated first (its pop on an empty stack is ignored).
    update(12'h200, 1'b1, 12'h300, 2'b11);
    for (int i = 1; i <= 5; i++) update(12'(i * 16), 1'b1, 12'h400, 2'b10);
    lookup("call_jalr", 12'h050, 1'b1, 1'b1, 12'h400);
`ifdef BRANCH_PREDICTOR_RAS_EN
    ret_exp[0] = 12'h054; ret_exp[1] = 12'h044; ret_exp[2] = 12'h034;
    ret_exp[3] = 12'h024; ret_exp[4] = 12'h300;
`else
    for (int i = 0; i < 5; i++) ret_exp[i] = 12'h300;
`endif
    for (int i = 0; i < 5; i++) begin
      lookup($sformatf("ret_%0d", i), 12'h200, 1'b1, 1'b1, ret_exp[i]);
      update(12'h200, 1'b1, 12'h300, 2'b11);            // pop
    end
    lookup("ret_empty_pop", 12'h200, 1'b1, 1'b1, 12'h300);

    // Leave one entry on the stack, then reset with a simultaneous update.
    update(12'h060, 1'b1, 12'h400, 2'b10);
    rst_n = 1'b0;
    lk_valid = 1'b1; lk_pc = 12'h080;
    upd_valid = 1'b1; upd_pc = 12'h300; upd_taken = 1'b1; upd_target = 12'h600; upd_type = 2'b01;
    exp_q.push_back('0);
    step();
    compare_pred("mid_reset");
    rst_n = 1'b1;
    lookup("post_rst_080", 12'h080, 1'b0, 1'b0, 12'h084);
    lookup("post_rst_140", 12'h140, 1'b0, 1'b0, 12'h144);
    lookup("post_rst_200", 12'h200, 1'b0, 1'b0, 12'h204);
    lookup("post_rst_300", 12'h300, 1'b0, 1'b0, 12'h304);

    // Stack cleared by reset: one push then one pop leaves it empty.
    update(12'h070, 1'b1, 12'h400, 2'b10);
    update(12'h200, 1'b1, 12'h300, 2'b11);
    lookup("ras_rst", 12'h200, 1'b1, 1'b1, 12'h300);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
